// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcode/funct
// constants, ALU control values and datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_OR  = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: fixed ADD/SUB for address and compare work,
// funct-driven operation for R-type execute.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_bad_funct
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_bad_funct   = 1'b0;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          default: o_bad_funct   = 1'b1;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback, stalls on
// mem_ready, and drives ALU control plus every datapath enable and mux select.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic [2:0] w_alu_control;
  logic       w_bad_funct;
  logic       w_mem_req, w_mem_write, w_ir_write, w_reg_write;
  logic       w_pc_write, w_branch, w_illegal;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // ALU op depends on state only, kept apart so the decoder feeds the main block acyclically.
  always_comb begin
    w_alu_op = ALUOP_ADD;
    case (r_state)
      S_BRANCH:  w_alu_op = ALUOP_SUB;
      S_EXECUTE: w_alu_op = ALUOP_FUNCT;
      default:   w_alu_op = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct       (funct),
    .o_alu_control (w_alu_control),
    .o_bad_funct   (w_bad_funct)
  );

  always_comb begin
    w_next      = S_FETCH;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    pc_src      = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH2;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        w_next    = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        iord        = 1'b1;
        w_mem_write = 1'b1;
        w_next      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        w_illegal = w_bad_funct;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset overrides every strobe in the same cycle, so a pending access is dropped at once.
  assign mem_req     = w_mem_req & ~reset;
  assign mem_write   = w_mem_write & ~reset;
  assign ir_write    = w_ir_write & ~reset;
  assign reg_write   = w_reg_write & ~reset;
  assign pc_en       = (w_pc_write | (w_branch & zero)) & ~reset;
  assign illegal_op  = w_illegal & ~reset;
  assign alu_control = reset ? ALU_ADD : w_alu_control;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its
// states and compares outputs against hand-computed values.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int cycles   = 0;
  int ir_pulses = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are then changed 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    cycles++;
  endtask

  // Let combinational outputs settle mid-cycle before sampling.
  task automatic settle();
    #1;
  endtask

  // Zero-wait FETCH of the given instruction; returns with the FSM in DECODE.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn; mem_ready = 1'b1; settle();
    check("fetch_state", 8'(state_dbg), 8'd0);
    tick();
    settle();
    check("decode_state", 8'(state_dbg), 8'd1);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    settle();
    check("rst_mem_req", 8'(mem_req), 8'd0);
    check("rst_alu_ctl", 8'(alu_control), 8'd2);
    check("rst_pc_en", 8'(pc_en), 8'd0);
    reset = 1'b0;

    // lw with two wait cycles in FETCH and in MEMRD: 9 cycles in total
    cycles = 0; ir_pulses = 0; opcode = 6'b100011; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("lw_fetch_wait_st", 8'(state_dbg), 8'd0);
      check("lw_fetch_wait_req", 8'({mem_req, ir_write, pc_en}), 8'b100);
      tick();
    end
    mem_ready = 1'b1; settle();
    check("lw_fetch_go", 8'({mem_req, iord, ir_write, pc_en, alu_src_a, alu_src_b, pc_src}), 8'b10110_01_0 << 1);
    check("lw_fetch_alu", 8'(alu_control), 8'd2);
    ir_pulses += ir_write;
    tick(); settle();
    ir_pulses += ir_write;
    check("lw_decode_srcb", 8'({state_dbg, alu_src_a, alu_src_b}), 8'b0001_0_11);
    tick(); settle();
    ir_pulses += ir_write;
    check("lw_memadr", 8'({state_dbg, alu_src_a, alu_src_b}), 8'b0010_1_10);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      ir_pulses += ir_write;
      check("lw_memrd_wait", 8'({state_dbg, mem_req, iord, mem_write}), 8'b0011_110);
      tick();
    end
    mem_ready = 1'b1; settle();
    check("lw_memrd_go", 8'(state_dbg), 8'd3);
    tick(); settle();
    ir_pulses += ir_write;
    check("lw_memwb", 8'({state_dbg, reg_write, reg_dst, mem_to_reg}), 8'b0100_101);
    tick(); settle();
    check("lw_done_state", 8'(state_dbg), 8'd0);
    check("lw_cycles", 8'(cycles), 8'd9);
    check("lw_ir_pulses", 8'(ir_pulses), 8'd1);

    // R-type sub
    fetch(6'b000000, 6'b100010);
    tick(); settle();
    check("sub_exec", 8'({state_dbg, alu_src_a, alu_src_b}), 8'b0110_1_00);
    check("sub_alu_ctl", 8'({illegal_op, alu_control}), 8'b0_110);
    tick(); settle();
    check("sub_aluwb", 8'({state_dbg, reg_write, reg_dst, mem_to_reg}), 8'b0111_110);
    tick(); settle();
    check("sub_done", 8'(state_dbg), 8'd0);

    // R-type and / or / slt / unknown funct in EXECUTE
    fetch(6'b000000, 6'b100100); tick(); settle();
    check("and_alu_ctl", 8'({illegal_op, alu_control}), 8'b0_001);
    tick(); tick();
    fetch(6'b000000, 6'b100101); tick(); settle();
    check("or_alu_ctl", 8'({illegal_op, alu_control}), 8'b0_000);
    tick(); tick();
    fetch(6'b000000, 6'b101010); tick(); settle();
    check("slt_alu_ctl", 8'({illegal_op, alu_control}), 8'b0_111);
    tick(); tick();
    fetch(6'b000000, 6'b111111); tick(); settle();
    check("badfn_exec", 8'({illegal_op, alu_control}), 8'b1_010);
    tick(); settle();
    check("badfn_aluwb", 8'({state_dbg, reg_write, illegal_op}), 8'b0111_10);
    tick();

    // beq taken, then not taken
    zero = 1'b1;
    fetch(6'b000100, 6'b0); tick(); settle();
    check("beq_t", 8'({state_dbg, pc_en, pc_src}), 8'b1000_1_01);
    check("beq_t_alu", 8'({alu_src_a, alu_src_b, alu_control}), 8'b1_00_110);
    zero = 1'b0; settle();
    check("beq_zero_dropped", 8'(pc_en), 8'd0);
    tick(); settle();
    check("beq_t_done", 8'(state_dbg), 8'd0);
    fetch(6'b000100, 6'b0); tick(); settle();
    check("beq_nt", 8'({state_dbg, pc_en, pc_src}), 8'b1000_0_01);
    tick();

    // illegal opcode
    mem_ready = 1'b1; opcode = 6'b111111; settle();
    tick(); settle();
    check("ill_decode", 8'({state_dbg, illegal_op, reg_write, mem_write, mem_req}), 8'b0001_1000);
    tick(); settle();
    check("ill_next", 8'({state_dbg, illegal_op}), 8'b0000_0);

    // addi
    fetch(6'b001000, 6'b0); tick(); settle();
    check("addi_ex", 8'({state_dbg, alu_src_a, alu_src_b}), 8'b1001_1_10);
    tick(); settle();
    check("addi_wb", 8'({state_dbg, reg_write, reg_dst, mem_to_reg}), 8'b1010_100);
    tick();

    // jump
    fetch(6'b000010, 6'b0); tick(); settle();
    check("j_jump", 8'({state_dbg, pc_en, pc_src}), 8'b1011_1_10);
    tick(); settle();
    check("j_done", 8'(state_dbg), 8'd0);

    // sw with immediate ready: one store cycle
    fetch(6'b101011, 6'b0); tick(); tick(); settle();
    check("sw_memwr", 8'({state_dbg, mem_req, iord, mem_write}), 8'b0101_111);
    tick(); settle();
    check("sw_after", 8'({state_dbg, mem_write}), 8'b0000_0);

    // reset during a stalled store
    fetch(6'b101011, 6'b0); tick(); mem_ready = 1'b0; tick(); settle();
    check("sw_stall", 8'({state_dbg, mem_write}), 8'b0101_1);
    reset = 1'b1; settle();
    check("rst_midwr_strobes", 8'({mem_write, mem_req}), 8'b00);
    tick(); settle();
    check("rst_midwr_state", 8'(state_dbg), 8'd0);
    reset = 1'b0; settle();
    check("post_rst_fetch", 8'({state_dbg, mem_req}), 8'b0000_1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
